// File: rtl/adc_sample_scheduler.sv
// Converter sequencer: periodic trigger generation, sample collection, optional
// box-car averaging and a first-word fall-through result FIFO on a stream port.
module adc_sample_scheduler #(
  parameter int CLOCK_PERIOD   = 10,
  parameter int MIN_PERIOD     = 520,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic [2:0]  avg_log2,
  output logic        adc_trigger,
  input  logic [15:0] adc_data,
  input  logic        adc_data_ready,
  output logic [15:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [15:0] missed_ticks,
  output logic [15:0] overflow_count,
  output logic        timeout_err,
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_PUSH  = 2'd2;
  localparam logic [1:0] S_GUARD = 2'd3;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CLOCK_PERIOD < 1 ||
      MIN_PERIOD < 4 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("adc_sample_scheduler: illegal parameter set");
  end

  logic              enable_q;
  logic [31:0]       period_eff_q, period_eff_d;
  logic [2:0]        avg_lat_q, avg_lat_d;
  logic [31:0]       tick_cnt_q, tick_cnt_d;
  logic [1:0]        state_q, state_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              guard_q, guard_d;
  logic [22:0]       acc_q, acc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              flush_q, flush_d;
  logic              trig_q, trig_d;
  logic              res_vld_q, res_vld_d;
  logic [15:0]       res_q, res_d;
  logic [15:0]       missed_q, missed_d;
  logic [15:0]       ovf_q, ovf_d;
  logic              tmo_err_q, tmo_err_d;
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]       mem_q [FIFO_DEPTH];

  logic cfg_latch, tick;
  logic fifo_empty, fifo_full, fifo_push, fifo_pop;

  // Tick generator: counter reloads on each tick so ticks land period_eff apart.
  always_comb begin
    cfg_latch    = enable & ~enable_q;
    tick         = enable & enable_q & (tick_cnt_q == 32'd0);
    period_eff_d = period_eff_q;
    avg_lat_d    = avg_lat_q;
    tick_cnt_d   = tick_cnt_q;
    if (cfg_latch) begin
      period_eff_d = (period < MIN_P) ? MIN_P : period;
      avg_lat_d    = avg_log2;
      tick_cnt_d   = 32'd0;
    end else if (enable) begin
      tick_cnt_d = tick ? (period_eff_q - 32'd1) : (tick_cnt_q - 32'd1);
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    guard_d   = guard_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    flush_d   = flush_q;
    trig_d    = 1'b0;
    res_vld_d = 1'b0;
    res_d     = res_q;
    tmo_err_d = tmo_err_q;
    missed_d  = missed_q;
    if (tick && state_q != S_IDLE && missed_q != 16'hFFFF)
      missed_d = missed_q + 16'd1;
    unique case (state_q)
      S_IDLE: begin
        // A run that was disabled mid-group never completes that group.
        if (!enable || flush_q) begin
          acc_d   = '0;
          cnt_d   = '0;
          flush_d = 1'b0;
        end
        if (tick) begin
          trig_d    = 1'b1;
          tmo_cnt_d = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (adc_data_ready) begin
          acc_d = acc_q + {7'd0, adc_data};
          cnt_d = cnt_q + 8'd1;
          if ((cnt_q + 8'd1) == (8'd1 << avg_lat_q)) begin
            state_d = S_PUSH;
          end else begin
            state_d = S_GUARD;
            guard_d = 1'b0;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_err_d = 1'b1;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_PUSH: begin
        res_vld_d = 1'b1;
        res_d     = acc_q[avg_lat_q +: 16];
        acc_d     = '0;
        cnt_d     = '0;
        guard_d   = 1'b0;
        state_d   = S_GUARD;
      end
      default: begin
        // Two idle cycles so the converter has released CS before a retrigger.
        if (guard_q) state_d = S_IDLE;
        else         guard_d = 1'b1;
      end
    endcase
    if (enable_q && !enable) flush_d = 1'b1;
  end

  // Result FIFO: a pop in the same cycle frees the slot for a push into a full FIFO.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    fifo_pop   = !fifo_empty && m_tready;
    fifo_push  = res_vld_q && (!fifo_full || fifo_pop);
    wr_ptr_d   = fifo_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = fifo_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d      = ovf_q;
    if (res_vld_q && !fifo_push && ovf_q != 16'hFFFF)
      ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q     <= 1'b0;
      period_eff_q <= '0;
      avg_lat_q    <= '0;
      tick_cnt_q   <= '0;
      state_q      <= S_IDLE;
      tmo_cnt_q    <= '0;
      guard_q      <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_q      <= 1'b0;
      trig_q       <= 1'b0;
      res_vld_q    <= 1'b0;
      res_q        <= '0;
      missed_q     <= '0;
      ovf_q        <= '0;
      tmo_err_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      enable_q     <= enable;
      period_eff_q <= period_eff_d;
      avg_lat_q    <= avg_lat_d;
      tick_cnt_q   <= tick_cnt_d;
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      guard_q      <= guard_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_q      <= flush_d;
      trig_q       <= trig_d;
      res_vld_q    <= res_vld_d;
      res_q        <= res_d;
      missed_q     <= missed_d;
      ovf_q        <= ovf_d;
      tmo_err_q    <= tmo_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= res_q;
  end

  assign adc_trigger    = trig_q;
  assign m_tvalid       = !fifo_empty;
  assign m_tdata        = fifo_empty ? 16'd0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign missed_ticks   = missed_q;
  assign overflow_count = ovf_q;
  assign timeout_err    = tmo_err_q;
  assign busy           = (state_q != S_IDLE);

endmodule
